// File: rtl/lab2_cla_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Optional signed-overflow output is enabled by defining LAB2_CLA_OVF_EN.
module lab2_cla_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef LAB2_CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned GROUPS = WIDTH / 4;

    generate
        if ((WIDTH < 4) || (WIDTH > 64) || ((WIDTH % 4) != 0)) begin : g_bad_width
            $error("lab2_cla_pipe: WIDTH must be a multiple of 4 in 4..64");
        end
    endgenerate

    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             c0_q, c0_d;
    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef LAB2_CLA_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             adv1, adv2;
    logic [WIDTH-1:0] b_eff;
    logic [GROUPS-1:0] pg, gg;
    logic [GROUPS:0]   gc;
    logic [WIDTH-1:0]  carry;

    // in_ready is a single OR of state and out_ready; it never looks at in_valid.
    assign adv2     = !s2_v_q || out_ready;
    assign adv1     = !s1_v_q || !s2_v_q || out_ready;
    assign in_ready = adv1;

    assign out_valid = s2_v_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef LAB2_CLA_OVF_EN
    assign ovf       = ovf_q;
`endif

    // Stage 1: bitwise propagate/generate and carry-in capture.
    always_comb begin
        b_eff  = sub ? ~b : b;
        s1_v_d = s1_v_q;
        p_d    = p_q;
        g_d    = g_q;
        c0_d   = c0_q;
        if (adv1) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                p_d  = a ^ b_eff;
                g_d  = a & b_eff;
                c0_d = sub | cin;
            end
        end
    end

    // Group P/G, second-level sum-of-products group carries, then in-group bit carries.
    always_comb begin
        logic term;
        pg    = '0;
        gg    = '0;
        gc    = '0;
        carry = '0;
        term  = 1'b0;
        for (int j = 0; j < int'(GROUPS); j++) begin
            pg[j] = &p_q[4*j +: 4];
            gg[j] = g_q[4*j+3]
                  | (p_q[4*j+3] & g_q[4*j+2])
                  | (p_q[4*j+3] & p_q[4*j+2] & g_q[4*j+1])
                  | (p_q[4*j+3] & p_q[4*j+2] & p_q[4*j+1] & g_q[4*j]);
        end
        gc[0] = c0_q;
        for (int j = 0; j < int'(GROUPS); j++) begin
            term = c0_q;
            for (int m = 0; m <= j; m++) begin
                term = term & pg[m];
            end
            gc[j+1] = term;
            for (int k = 0; k <= j; k++) begin
                term = gg[k];
                for (int m = k + 1; m <= j; m++) begin
                    term = term & pg[m];
                end
                gc[j+1] = gc[j+1] | term;
            end
        end
        for (int j = 0; j < int'(GROUPS); j++) begin
            carry[4*j]   = gc[j];
            carry[4*j+1] = g_q[4*j] | (p_q[4*j] & gc[j]);
            carry[4*j+2] = g_q[4*j+1] | (p_q[4*j+1] & g_q[4*j])
                         | (p_q[4*j+1] & p_q[4*j] & gc[j]);
            carry[4*j+3] = g_q[4*j+2] | (p_q[4*j+2] & g_q[4*j+1])
                         | (p_q[4*j+2] & p_q[4*j+1] & g_q[4*j])
                         | (p_q[4*j+2] & p_q[4*j+1] & p_q[4*j] & gc[j]);
        end
    end

    // Stage 2: result capture, held while the consumer stalls.
    always_comb begin
        s2_v_d = s2_v_q;
        sum_d  = sum_q;
        cout_d = cout_q;
`ifdef LAB2_CLA_OVF_EN
        ovf_d  = ovf_q;
`endif
        if (adv2) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                sum_d  = p_q ^ carry;
                cout_d = gc[GROUPS];
`ifdef LAB2_CLA_OVF_EN
                ovf_d  = carry[WIDTH-1] ^ gc[GROUPS];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            p_q    <= '0;
            g_q    <= '0;
            c0_q   <= 1'b0;
            s2_v_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef LAB2_CLA_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            s1_v_q <= s1_v_d;
            p_q    <= p_d;
            g_q    <= g_d;
            c0_q   <= c0_d;
            s2_v_q <= s2_v_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
`ifdef LAB2_CLA_OVF_EN
            ovf_q  <= ovf_d;
`endif
        end
    end

endmodule

// File: doc/lab2_cla_pipe.md
# lab2_cla_pipe

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides. Operands are split into 4-bit lookahead groups, and a second-level lookahead combines the group generate/propagate terms into group carries. It is the multi-group, registered successor to the Lab 2 4-bit carry-lookahead generator, and serves as the arithmetic unit for later labs' datapaths.

## Interface
Parameters:
- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4, from 4 to 64. Other values are unsupported, and an elaboration check flags them.
- `GROUPS`, derived as `WIDTH/4`: number of 4-bit lookahead groups. Not overridable.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand beat is present.
- `in_ready` output 1: block accepts a beat this cycle.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: carry-in. Ignored when `sub`=1.
- `sub` input 1: 0 computes A+B+cin; 1 computes A+~B+1.
- `out_valid` output 1: result beat is present.
- `out_ready` input 1: downstream accepts the result.
- `sum` output WIDTH: result.
- `cout` output 1: carry out of bit WIDTH-1. When `sub`=1 this is the no-borrow flag.
- `ovf` output 1: signed overflow. Present only with `LAB2_CLA_OVF_EN`.

## Operation
- Accept: a beat is accepted on a rising edge where `in_valid && in_ready`.
- Stage 1 register contents on accept:
  - p_i = a_i ^ b'_i
  - g_i = a_i & b'_i
  - c0 = sub ? 1 : cin
  - b' = sub ? ~b : b
- Stage 1 to stage 2 (combinational):
  - Per group j: group propagate PG_j = &p[4j+3:4j].
  - Group generate GG_j uses the 4-bit lookahead form: g3 | p3g2 | p3p2g1 | p3p2p1g0.
  - Group carries come from a second-level lookahead over (PG, GG, c0): C_{j+1} = GG_j | PG_j·C_j, expanded in sum-of-products form. A ripple chain through the groups is not permitted.
  - Bit carries inside each group use the 4-bit lookahead equations seeded by C_j.
- Stage 2 register contents:
  - `sum` = p ^ carries[WIDTH-1:0]
  - `cout` = C_GROUPS
  - `ovf`, if enabled
- Flow control uses stage valids s1_v and s2_v:
  - adv2 = !s2_v || out_ready
  - adv1 = !s1_v || adv2
  - `in_ready` = adv1
  - `in_ready` is combinational from `out_ready` and the internal state only. It never depends on `in_valid`.
- Throughput: one beat per cycle when `out_ready` is held high.
- Stall:
  - `sum`, `cout` and `ovf` hold stable while `out_valid && !out_ready`.
  - Stage 1 holds while adv2=0.
  - The block stores at most 2 beats.
- Simultaneous output handshake and new accept in the same cycle: both take effect with no bubble.
- Drop and duplication: no beat is ever dropped or duplicated.
- Reset (asynchronous; also applies mid-operation):
  - s1_v=0, s2_v=0, so `out_valid`=0.
  - `sum`=0, `cout`=0, `ovf`=0.
  - `in_ready`=1.
  - In-flight beats are discarded.
  - Release of `rst_n` is synchronised by the system; no internal synchroniser.

## Timing
- Latency: a beat accepted at edge k appears with `out_valid`=1 after edge k+1, provided stage 2 was free or drained at k+1.
- Combinational path from `out_ready` to `in_ready`: exactly one level of logic. No path from `a`, `b` or `cin` to any output.
- After reset release: `in_ready`=1 in the first cycle, and the first accept is possible at the first rising edge.

## Configuration
- `LAB2_CLA_OVF_EN` defined:
  - Port `ovf` exists.
  - `ovf` = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, registered in stage 2 alongside `sum`.
  - Reset value is 0.
- `LAB2_CLA_OVF_EN` undefined: port `ovf` and its register are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=16.
- Add with carry out: a=0xFFFF, b=0x0001, cin=0, sub=0 -> 2 edges later `sum`=0x0000, `cout`=1.
- Add with carry-in: a=0x1234, b=0x4321, cin=1 -> `sum`=0x5556, `cout`=0.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 -> `sum`=0xFFFE, `cout`=0. Also a=0x0007, b=0x0005 -> `sum`=0x0002, `cout`=1.
- Backpressure:
  - Stimulus: `in_valid`=1 with beats 1, 2, 3, 4 and `out_ready`=0.
  - Required: exactly 2 beats accepted, then `in_ready`=0 with `sum` stable.
  - Then raise `out_ready`=1 -> results emerge in order, one per cycle, none lost or duplicated.
- Reset mid-operation: 2 beats in flight, pull `rst_n` low between edges -> `out_valid`=0, `sum`=0 and `in_ready`=1 immediately, and no stale result after release.
- With `LAB2_CLA_OVF_EN`:
  - 0x7FFF + 0x0001 -> `ovf`=1, `sum`=0x8000.
  - 0x8000 − 0x0001 (sub=1) -> `ovf`=1, `sum`=0x7FFF.
  - 0x0001 + 0x0001 -> `ovf`=0.
